// File: rtl/core_pkg.sv
// Shared core types and constants: register index/word types and the
// architectural register numbers the register file treats specially.
package core_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0]        reg_idx_t;
    typedef logic signed [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
    localparam reg_idx_t REG_SP   = reg_idx_t'(2);

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file: zero-register masking
// plus, when REG_FILE_BYPASS_EN is defined, same-cycle write forwarding.
module reg_file_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [DATA_W-1:0] regs [NREGS],
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] data
);
    import core_pkg::*;

    logic is_zero;
    assign is_zero = (addr == ADDR_W'(REG_ZERO));

`ifdef REG_FILE_BYPASS_EN
    logic fwd;
    // The value in flight wins over storage, except while reset holds state.
    assign fwd = !rst && we && (wr_addr != ADDR_W'(REG_ZERO)) && (wr_addr == addr);

    always_comb begin
        data = regs[addr];
        if (is_zero) begin
            data = '0;
        end else if (fwd) begin
            data = wr_data;
        end
    end
`else
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{rst, we, wr_addr, wr_data};

    always_comb begin
        data = regs[addr];
        if (is_zero) begin
            data = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one clocked write
// port, r0 hardwired to zero, sp resets to SP_RESET. Macro REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int                 DATA_W   = core_pkg::DATA_W,
    parameter int                 ADDR_W   = core_pkg::ADDR_W,
    parameter logic [DATA_W-1:0]  SP_RESET = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rs1_addr,
    input  logic [ADDR_W-1:0]        rs2_addr,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    input  logic                     we,
    output logic signed [DATA_W-1:0] rs1_data,
    output logic signed [DATA_W-1:0] rs2_data
);
    import core_pkg::*;

    localparam int NREGS = 2**ADDR_W;

    logic signed [DATA_W-1:0] regs [NREGS];

    // Slot 0 exists only so the read muxes can index uniformly; it is never stored.
    assign regs[0] = '0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
            localparam logic signed [DATA_W-1:0] RST_VAL =
                (gi == int'(REG_SP)) ? SP_RESET : '0;

            logic signed [DATA_W-1:0] value_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    value_reg <= RST_VAL;
                end else if (we && (rd_addr == ADDR_W'(gi))) begin
                    value_reg <= rd_data;
                end
            end

            assign regs[gi] = value_reg;
        end
    endgenerate

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rd_port1 (
        .rst     (rst),
        .addr    (rs1_addr),
        .regs    (regs),
        .we      (we),
        .wr_addr (rd_addr),
        .wr_data (rd_data),
        .data    (rs1_data)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rd_port2 (
        .rst     (rst),
        .addr    (rs2_addr),
        .regs    (regs),
        .we      (we),
        .wr_addr (rd_addr),
        .wr_data (rd_data),
        .data    (rs2_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps followed by random traffic
// checked against an array model of the architectural registers.
module tb_reg_file;

    localparam logic [31:0] SP_RST = 32'h0000_8000;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic signed [31:0] rd_data;
    logic        we;
    logic signed [31:0] rs1_data;
    logic signed [31:0] rs2_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    reg_file #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .SP_RESET (SP_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .we       (we),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[2] = SP_RST;
    endfunction

    // What a read port should show right now, given the current inputs.
    function automatic logic [31:0] expect_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (!rst && we && rd_addr == a) return rd_data;
`endif
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
        check($sformatf("%s rs1[%0d]", tag, a1), rs1_data, expect_read(a1));
        check($sformatf("%s rs2[%0d]", tag, a2), rs2_data, expect_read(a2));
        $display("%s: rs1[%0d]=%h rs2[%0d]=%h", tag, a1, rs1_data, a2, rs2_data);
    endtask

    // One clock cycle: drive write inputs after the falling edge, check reads
    // before and after the rising edge.
    task automatic cycle(input string tag, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        we      = w;
        rd_addr = wa;
        rd_data = wd;
        read_check({tag, " pre"}, a1, a2);
        @(posedge clk);
        if (!rst && w && wa != 5'd0) model[wa] = wd;
        #1;
        read_check({tag, " post"}, a1, a2);
    endtask

    initial begin
        clk_run  = 1'b0;
        rst      = 1'b1;
        we       = 1'b0;
        rd_addr  = '0;
        rd_data  = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        model_reset();
        #1;

        // Reset values with no clock running.
        for (int i = 0; i < 32; i++) begin
            read_check("reset", 5'(i), 5'(31 - i));
        end

        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        cycle("wr5",   1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5, 5'd31);
        cycle("wr31",  1'b1, 5'd31, 32'hFFFF_FFF0, 5'd5, 5'd31);
        read_check("rd5_31", 5'd5, 5'd31);
        check("rs2 signed -16", 32'(rs2_data), 32'(-16));

        cycle("wr0",   1'b1, 5'd0,  32'h1234_5678, 5'd0, 5'd0);

        cycle("pre7",  1'b1, 5'd7,  32'h0000_0777, 5'd7, 5'd2);
        cycle("byp7",  1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7, 5'd7);

        // Reset between edges with a write pending.
        cycle("wr10",  1'b1, 5'd10, 32'h0000_0042, 5'd10, 5'd2);
        @(negedge clk);
        we      = 1'b1;
        rd_addr = 5'd10;
        rd_data = 32'h0000_0099;
        #1;
        rst = 1'b1;
        model_reset();
        read_check("midrst", 5'd10, 5'd2);
        @(posedge clk);
        #1;
        read_check("midrst edge", 5'd10, 5'd2);
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b0;
        read_check("rst rel", 5'd10, 5'd5);

        cycle("wr3",   1'b1, 5'd3, 32'h0BAD_F00D, 5'd3, 5'd2);
        for (int i = 0; i < 4; i++) begin
            cycle("we0",  1'b0, 5'd3, 32'h0000_0001, 5'd3, 5'd3);
        end

        for (int i = 0; i < 200; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  32'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Same index on both ports after random writes.
        for (int i = 0; i < 32; i++) begin
            we = 1'b0;
            read_check("final", 5'(i), 5'(i));
            check($sformatf("ports agree %0d", i), rs1_data, rs2_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the single-cycle core. Sits directly upstream of the ALU: two combinational read ports drive the ALU `A`/`B` operands, and one clocked write port takes the writeback value (ALU result or load data) at the end of each instruction. Register 0 is hardwired to zero. Register 2 (stack pointer) has a configurable reset value.

## Interface

**Parameters**
- `DATA_W`, 32: register width; matches ALU operand width.
- `ADDR_W`, 5: register index width; `NREGS = 2**ADDR_W` = 32 registers.
- `SP_RESET`, 32'h0000_0000: reset value of register 2 (sp). All other registers reset to 0.

**Ports** (clock and reset first)
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, **asynchronous, active-high**; clears all state immediately on assertion.
- `rs1_addr` input ADDR_W: read port 1 index.
- `rs2_addr` input ADDR_W: read port 2 index.
- `rd_addr` input ADDR_W: write port index.
- `rd_data` input DATA_W (signed): write data.
- `we` input 1: write enable, sampled at `clk` rising edge.
- `rs1_data` output DATA_W (signed): read port 1 data, to ALU `A`.
- `rs2_data` output DATA_W (signed): read port 2 data, to ALU `B`.

## Operation

- **Storage.** Registers 1..NREGS-1 are DATA_W-bit flops. Register 0 is not stored and always reads 0.
- **Write.** On a `clk` rising edge with `we`=1 and `rd_addr`≠0, `regs[rd_addr]` ← `rd_data`. A write to index 0 is silently dropped. With `we`=0, no state changes.
- **Read.** Both read ports are purely combinational, with no clock in the path:
  - `rsN_data` = 0 when `rsN_addr`=0.
  - Otherwise `rsN_data` = `regs[rsN_addr]`.
- **Same index on both ports.** Both outputs carry the same value.
- **Reset.**
  - While `rst`=1, every register is 0 except register 2, which is `SP_RESET`. Writes are ignored.
  - Outputs therefore read 0, or `SP_RESET` for index 2, during reset, with no clock needed.
  - If reset is asserted mid-cycle, a write that was pending at the next edge is lost.
  - On release, the first write occurs at the first rising edge with `rst`=0.
- **Simultaneous read/write of the same index.** Behaviour is defined under Configuration.
- **Width.** Values are stored verbatim, with no sign extension or truncation. `DATA_W` must match the ALU.

## Timing

- Read latency: 0 cycles (combinational from address to data).
- Write latency: the value is visible on read ports in the cycle after the write edge. The same-cycle case follows the bypass setting.
- Reset: asynchronous assert. Deassertion must be synchronised externally to `clk`; the block does no synchronisation.
- No handshake: the caller guarantees `rd_addr`, `rd_data` and `we` are stable around the edge. This is a single-cycle core, so one write per cycle at most.

## Configuration

Macro **`REG_FILE_BYPASS_EN`**.

- **Defined:** write-to-read forwarding is compiled in.
  - If `we`=1, `rd_addr`≠0 and `rsN_addr`=`rd_addr`, then `rsN_data` = `rd_data` combinationally in the same cycle.
  - Index 0 still reads 0.
  - Forwarding is ignored while `rst`=1.
- **Not defined:** reads always return stored contents. In the same cycle, the old value is returned until the edge.
- The default build leaves the macro undefined. The single-cycle datapath does not need forwarding; it is reserved for a future pipelined variant.

## Structure

- **Shared package `core_pkg`:**
  - `DATA_W` and `ADDR_W` defaults.
  - `reg_idx_t` typedef (logic [ADDR_W-1:0]).
  - `word_t` typedef (logic signed [DATA_W-1:0]).
  - Constants `REG_ZERO`=0 and `REG_SP`=2.
- **One sub-module: `reg_file_rd_port`.** It is the per-port read mux that applies zero-register masking and, under the macro, bypass. It is instantiated twice.
- The storage array and write logic live in `reg_file`.

## Test plan

1. **Reset values.** Assert `rst` with no clock edges, then read all 32 indices → every index returns 0, except index 2, which returns `SP_RESET`.
2. **Write then read.** Write 32'hDEAD_BEEF to index 5 and 32'hFFFF_FFF0 to index 31 on successive edges, then read 5 on port 1 and 31 on port 2 → DEAD_BEEF and FFFF_FFF0 (signed -16).
3. **Zero register.** Set `we`=1, `rd_addr`=0, `rd_data`=32'h1234_5678, then read index 0 on both ports → 0 on both.
4. **Same-cycle read/write.** Write 32'hA5A5_A5A5 to index 7 while reading 7 on port 1 before the edge:
   - Macro undefined → old value.
   - Macro defined → A5A5_A5A5.
   - After the edge, both builds → A5A5_A5A5.
5. **Reset mid-operation.** Write 32'h0000_0042 to index 10, then assert `rst` between edges with `we`=1 pending → index 10 reads 0 immediately and remains 0 after the next edge while `rst`=1.
6. **We low.** Set `we`=0 with `rd_addr`=3 and `rd_data`=32'h1 for 4 edges → index 3 is unchanged from its prior value.
